// File: rtl/hazard_controller.sv
// Pipeline hazard controller: freezes the pipeline on outstanding memory
// accesses, inserts load-use bubbles, flushes on EX redirects, and keeps
// performance counters plus a sticky memory-stall watchdog.
module hazard_controller #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        exmem_mem_read,
    input  logic        exmem_mem_write,
    input  logic        dmem_resp,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_use_rs1,
    input  logic        ifid_use_rs2,
    input  logic        ex_redirect,
    output logic        pc_ld,
    output logic        ifid_ld,
    output logic        idex_ld,
    output logic        exmem_ld,
    output logic        memwb_ld,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        imem_read_gated,
    output logic        dmem_read_gated,
    output logic        dmem_write_gated,
    output logic [31:0] inst_out,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count,
    output logic        mem_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t          state;
    logic            imem_done;
    logic            dmem_done;
    logic [31:0]     inst_hold;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_inc;

    logic imem_sat;
    logic dmem_sat;
    logic mem_stall;
    logic redirect_now;
    logic load_use;

    // Memory-side satisfaction, stall decision and hazard detection
    always_comb begin
        imem_sat     = !imem_read || imem_resp || imem_done;
        dmem_sat     = !(exmem_mem_read || exmem_mem_write) || dmem_resp || dmem_done;
        mem_stall    = !(imem_sat && dmem_sat);
        redirect_now = ex_redirect && !mem_stall;
        load_use     = !mem_stall && !ex_redirect && idex_mem_read && (idex_rd != 5'd0) &&
                       ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                        (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
        wd_inc       = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + WD_W'(1);
    end

    // Pipeline load/flush control; memory stall dominates, then redirect, then load-use
    always_comb begin
        pc_ld      = 1'b1;
        ifid_ld    = 1'b1;
        idex_ld    = 1'b1;
        exmem_ld   = 1'b1;
        memwb_ld   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (mem_stall) begin
            pc_ld    = 1'b0;
            ifid_ld  = 1'b0;
            idex_ld  = 1'b0;
            exmem_ld = 1'b0;
            memwb_ld = 1'b0;
        end else if (redirect_now) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID; the bubble enters ID/EX while older stages advance
            pc_ld      = 1'b0;
            ifid_ld    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Requests to memory are masked once that side has completed, so nothing is reissued
    always_comb begin
        imem_read_gated  = imem_read && !imem_done;
        dmem_read_gated  = exmem_mem_read && !dmem_done;
        dmem_write_gated = exmem_mem_write && !dmem_done;
        inst_out         = imem_resp ? imem_rdata : inst_hold;
    end

    // Stall FSM, per-side completion flags and the memory-stall watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            imem_done   <= 1'b0;
            dmem_done   <= 1'b0;
            wd_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= mem_stall ? MEM_WAIT : RUN;
            if (!mem_stall) begin
                imem_done <= 1'b0;
                dmem_done <= 1'b0;
            end else begin
                if (imem_resp) imem_done <= 1'b1;
                if (dmem_resp) dmem_done <= 1'b1;
            end
            if (state == MEM_WAIT) begin
                wd_cnt <= mem_stall ? wd_inc : '0;
                if (wd_inc == WD_MAX) mem_timeout <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // Keep the fetched word while the data side is still outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_hold <= '0;
        end else if (mem_stall && imem_resp) begin
            inst_hold <= imem_rdata;
        end
    end

    // Performance counters, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (mem_stall || load_use) stall_cycles <= stall_cycles + 32'd1;
            if (load_use)              bubble_count <= bubble_count + 32'd1;
            if (redirect_now)          flush_count  <= flush_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the controller's rules.
module tb_hazard_controller;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        imem_read, imem_resp;
    logic [31:0] imem_rdata;
    logic        exmem_mem_read, exmem_mem_write, dmem_resp;
    logic        idex_mem_read;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        ifid_use_rs1, ifid_use_rs2, ex_redirect;
    logic        pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;
    logic        ifid_flush, idex_flush;
    logic        imem_read_gated, dmem_read_gated, dmem_write_gated;
    logic [31:0] inst_out, stall_cycles, bubble_count, flush_count;
    logic        mem_timeout;

    hazard_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
        .dmem_resp(dmem_resp), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .ex_redirect(ex_redirect),
        .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld),
        .exmem_ld(exmem_ld), .memwb_ld(memwb_ld),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .imem_read_gated(imem_read_gated), .dmem_read_gated(dmem_read_gated),
        .dmem_write_gated(dmem_write_gated), .inst_out(inst_out),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count),
        .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what has been delivered for the current access, the
    // word delivered early, running event tallies and the wait-streak length.
    bit          m_fetch_delivered;
    bit          m_data_delivered;
    logic [31:0] m_word;
    logic [31:0] m_stalls, m_bubbles, m_flushes;
    int          m_wait_streak;
    bit          m_waiting;
    bit          m_timed_out;

    task automatic model_reset();
        m_fetch_delivered = 0;
        m_data_delivered  = 0;
        m_word            = '0;
        m_stalls          = '0;
        m_bubbles         = '0;
        m_flushes         = '0;
        m_wait_streak     = 0;
        m_waiting         = 0;
        m_timed_out       = 0;
    endtask

    // One clock cycle: predict outputs from the rules, compare at the falling
    // edge, then advance the model with the inputs seen at the rising edge.
    task automatic run_cycle();
        bit fetch_ok, data_ok, frozen, redirect, bubble;
        logic [4:0]  exp_ld;
        logic [1:0]  exp_fl;
        logic [2:0]  exp_gate;
        logic [31:0] exp_inst;
        fetch_ok = !imem_read || imem_resp || m_fetch_delivered;
        data_ok  = !(exmem_mem_read || exmem_mem_write) || dmem_resp || m_data_delivered;
        frozen   = !(fetch_ok && data_ok);
        redirect = !frozen && ex_redirect;
        bubble   = !frozen && !ex_redirect && idex_mem_read && idex_rd != 0 &&
                   ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
        if (frozen)      begin exp_ld = 5'b00000; exp_fl = 2'b00; end
        else if (redirect) begin exp_ld = 5'b11111; exp_fl = 2'b11; end
        else if (bubble) begin exp_ld = 5'b00111; exp_fl = 2'b01; end
        else             begin exp_ld = 5'b11111; exp_fl = 2'b00; end
        exp_gate = {imem_read && !m_fetch_delivered,
                    exmem_mem_read && !m_data_delivered,
                    exmem_mem_write && !m_data_delivered};
        exp_inst = imem_resp ? imem_rdata : m_word;
        #4;
        check_val("ld_vec", 32'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), 32'(exp_ld));
        check_val("flush_vec", 32'({ifid_flush, idex_flush}), 32'(exp_fl));
        check_val("gated_req", 32'({imem_read_gated, dmem_read_gated, dmem_write_gated}), 32'(exp_gate));
        check_val("inst_out", inst_out, exp_inst);
        check_val("stall_cycles", stall_cycles, m_stalls);
        check_val("bubble_count", bubble_count, m_bubbles);
        check_val("flush_count", flush_count, m_flushes);
        check_val("mem_timeout", 32'(mem_timeout), 32'(m_timed_out));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (frozen) begin
                if (imem_resp) begin m_fetch_delivered = 1; m_word = imem_rdata; end
                if (dmem_resp) m_data_delivered = 1;
            end else begin
                m_fetch_delivered = 0;
                m_data_delivered  = 0;
            end
            if (frozen || bubble) m_stalls  = m_stalls + 1;
            if (bubble)           m_bubbles = m_bubbles + 1;
            if (redirect)         m_flushes = m_flushes + 1;
            if (m_waiting) begin
                m_wait_streak++;
                if (m_wait_streak >= TO) m_timed_out = 1;
            end else begin
                m_wait_streak = 0;
            end
            m_waiting = frozen;
        end
        #1;
    endtask

    task automatic clear_inputs();
        imem_read = 0; imem_resp = 0; imem_rdata = '0;
        exmem_mem_read = 0; exmem_mem_write = 0; dmem_resp = 0;
        idex_mem_read = 0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
        ifid_use_rs1 = 0; ifid_use_rs2 = 0; ex_redirect = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        run_cycle();
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        #1;
        check_val("reset_stall_cycles", stall_cycles, 32'd0);
        check_val("reset_inst_out", inst_out, 32'd0);
        check_val("reset_timeout", 32'(mem_timeout), 32'd0);

        // Load-use on rs1 = x5: one bubble
        idex_mem_read = 1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_use_rs1 = 1;
        #1;
        check_val("lu_pc_ifid", 32'({pc_ld, ifid_ld, idex_flush}), 32'b001);
        run_cycle();
        clear_inputs();
        run_cycle();
        check_val("lu_bubble_count", bubble_count, 32'd1);

        // Load to x0 never stalls
        idex_mem_read = 1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_use_rs1 = 1;
        #1;
        check_val("x0_ld_all", 32'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), 32'h1f);
        run_cycle();

        // Split responses: imem at cycle 2, dmem at cycle 5
        do_reset();
        imem_read = 1; exmem_mem_read = 1;
        for (int c = 0; c < 6; c++) begin
            imem_resp  = (c == 2);
            imem_rdata = (c == 2) ? 32'hCAFE_F00D : 32'h1234_5678;
            dmem_resp  = (c == 5);
            #1;
            if (c < 5) check_val("split_ld_low", 32'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), 32'h0);
            else       check_val("split_ld_high", 32'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), 32'h1f);
            if (c >= 3) check_val("split_igate", 32'(imem_read_gated), 32'd0);
            if (c == 5) check_val("split_inst", inst_out, 32'hCAFE_F00D);
            run_cycle();
        end
        clear_inputs();
        check_val("split_stalls", stall_cycles, 32'd5);

        // Redirect held off behind a data stall
        do_reset();
        exmem_mem_read = 1; ex_redirect = 1;
        for (int c = 0; c < 4; c++) begin
            dmem_resp = (c == 3);
            #1;
            check_val("redir_stall_flush", 32'({ifid_flush, idex_flush}), (c == 3) ? 32'd3 : 32'd0);
            run_cycle();
        end
        clear_inputs();
        check_val("redir_stall_count", flush_count, 32'd1);

        // Redirect beats a simultaneous load-use hazard
        do_reset();
        ex_redirect = 1; idex_mem_read = 1; idex_rd = 5'd7; ifid_rs2 = 5'd7; ifid_use_rs2 = 1;
        #1;
        check_val("redir_lu_ctl", 32'({ifid_flush, idex_flush, pc_ld}), 32'b111);
        run_cycle();
        clear_inputs();
        check_val("redir_lu_bubbles", bubble_count, 32'd0);
        check_val("redir_lu_flushes", flush_count, 32'd1);

        // Watchdog: no responses
        do_reset();
        imem_read = 1;
        for (int c = 0; c < 9; c++) begin
            #1;
            check_val("wd_before", 32'(mem_timeout), 32'd0);
            run_cycle();
        end
        check_val("wd_rise", 32'(mem_timeout), 32'd1);
        imem_resp = 1; imem_rdata = 32'hA5A5_0001;
        run_cycle();
        clear_inputs();
        run_cycle();
        check_val("wd_sticky", 32'(mem_timeout), 32'd1);
        do_reset();
        check_val("wd_cleared", 32'(mem_timeout), 32'd0);

        // Randomized traffic; EX/ID/MEM fields stay frozen while stalled
        for (int i = 0; i < 1500; i++) begin
            if (!m_waiting) begin
                imem_read       = ($urandom_range(0, 1) == 1);
                exmem_mem_read  = ($urandom_range(0, 3) == 0);
                exmem_mem_write = !exmem_mem_read && ($urandom_range(0, 3) == 0);
                idex_mem_read   = ($urandom_range(0, 1) == 1);
                idex_rd         = 5'($urandom_range(0, 3));
                ifid_rs1        = 5'($urandom_range(0, 3));
                ifid_rs2        = 5'($urandom_range(0, 3));
                ifid_use_rs1    = ($urandom_range(0, 1) == 1);
                ifid_use_rs2    = ($urandom_range(0, 1) == 1);
                ex_redirect     = ($urandom_range(0, 4) == 0);
            end
            imem_resp  = imem_read && !m_fetch_delivered && ($urandom_range(0, 2) == 0);
            dmem_resp  = (exmem_mem_read || exmem_mem_write) && !m_data_delivered &&
                         ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            rst        = ($urandom_range(0, 199) == 0);
            run_cycle();
            rst = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
